// File: rtl/boot_ctrl_pkg.sv
// Shared types and constants for the boot SRAM loader: FSM state encoding,
// control-word bit positions and the reset-timer width helper.
package boot_ctrl_pkg;

  typedef enum logic [2:0] {
    COPY_RD  = 3'd0,
    COPY_CAP = 3'd1,
    COPY_WR  = 3'd2,
    RUN      = 3'd3,
    HOLD     = 3'd4
  } state_e;

  localparam int CFG_BOOT_BIT = 0;
  localparam int CFG_RST_BIT  = 1;

  // A one-cycle pulse still needs a 1-bit counter.
  function automatic int cnt_width(input int pulse);
    return (pulse > 1) ? $clog2(pulse) : 1;
  endfunction

endpackage

// File: rtl/boot_ctrl_rst_timer.sv
// Loadable down-counter that times the software-requested CPU reset hold;
// done_o is high while the count is zero.
module boot_ctrl_rst_timer
  import boot_ctrl_pkg::*;
#(
  parameter int RST_PULSE = 100
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic cke_i,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int CNT_W = cnt_width(RST_PULSE);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RST_PULSE - 1);

  logic [CNT_W-1:0] cnt_r;

  // count register: load takes priority, decrement saturates at zero
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_r <= CNT_W'(0);
    end else if (cke_i) begin
      if (load_i) begin
        cnt_r <= LOAD_VAL;
      end else if (dec_i && (cnt_r != CNT_W'(0))) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
    end
  end

  assign done_o = (cnt_r == CNT_W'(0));

endmodule

// File: rtl/boot_ctrl.sv
// Boot SRAM sequencer: copies the ROM image into SRAM with the CPU held in reset,
// then serves the boot flag / CPU reset control word. Optional: BOOT_CTRL_CHECKSUM_EN.
module boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 12,
  parameter int ROM_ADDR_W = 10,
  parameter int ROM_WORDS  = 256,
  parameter int SRAM_BASE  = 0,
  parameter int RST_PULSE  = 100
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  cfg_valid_i,
  input  logic [1:0]            cfg_wdata_i,
  output logic                  cfg_ready_o,
  output logic                  rom_en_o,
  output logic [ROM_ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0]     rom_data_i,
  output logic                  sram_valid_o,
  input  logic                  sram_ready_i,
  output logic [ADDR_W-1:0]     sram_addr_o,
  output logic [DATA_W-1:0]     sram_wdata_o,
  output logic [DATA_W/8-1:0]   sram_wstrb_o,
  output logic                  boot_o,
  output logic                  cpu_reset_o,
  output logic                  busy_o,
  output logic [DATA_W-1:0]     checksum_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ROM_ADDR_W-1:0] LAST_IDX  = ROM_ADDR_W'(ROM_WORDS - 1);
  localparam logic [ADDR_W-1:0]     BASE_ADDR = ADDR_W'(SRAM_BASE);

  state_e                  state_r, state_nxt_s;
  logic                    live_r;
  logic [ROM_ADDR_W-1:0]   idx_r;
  logic [DATA_W-1:0]       buf_r;
  logic                    boot_r;
  logic                    wr_hs_s, cfg_hs_s, hold_done_s, reload_s, timer_load_s;
  logic                    rom_en_s, sram_valid_s, cfg_ready_s, cpu_reset_s, busy_s;
  logic                    rom_en_r, sram_valid_r, cfg_ready_r, cpu_reset_r, busy_r;

  assign wr_hs_s      = (state_r == COPY_WR) && sram_ready_i;
  assign cfg_hs_s     = (state_r == RUN) && cfg_valid_i;
  assign timer_load_s = cfg_hs_s && cfg_wdata_i[CFG_RST_BIT];
  assign reload_s     = (state_r == HOLD) && hold_done_s && boot_r;

  boot_ctrl_rst_timer #(
    .RST_PULSE (RST_PULSE)
  ) u_rst_timer (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .load_i   (timer_load_s),
    .dec_i    (state_r == HOLD),
    .done_o   (hold_done_s)
  );

  // state register; live_r holds the FSM in COPY_RD for the first enabled cycle after reset
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r <= COPY_RD;
      live_r  <= 1'b0;
    end else if (cke_i) begin
      state_r <= state_nxt_s;
      live_r  <= 1'b1;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      COPY_RD: begin
        if (live_r) state_nxt_s = COPY_CAP;
        else        state_nxt_s = COPY_RD;
      end
      COPY_CAP: state_nxt_s = COPY_WR;
      COPY_WR: begin
        if (sram_ready_i) state_nxt_s = (idx_r == LAST_IDX) ? RUN : COPY_RD;
        else              state_nxt_s = COPY_WR;
      end
      RUN: begin
        if (timer_load_s) state_nxt_s = HOLD;
        else              state_nxt_s = RUN;
      end
      HOLD: begin
        if (hold_done_s) state_nxt_s = boot_r ? COPY_RD : RUN;
        else             state_nxt_s = HOLD;
      end
      default: state_nxt_s = COPY_RD;
    endcase
  end

  // output decode from the next state so the registered outputs line up with state_r
  always_comb begin
    rom_en_s     = 1'b0;
    sram_valid_s = 1'b0;
    cfg_ready_s  = 1'b0;
    cpu_reset_s  = 1'b1;
    busy_s       = 1'b0;
    case (state_nxt_s)
      COPY_RD:  begin rom_en_s = 1'b1;     busy_s = 1'b1; end
      COPY_CAP: begin busy_s = 1'b1; end
      COPY_WR:  begin sram_valid_s = 1'b1; busy_s = 1'b1; end
      RUN:      begin cfg_ready_s = 1'b1;  cpu_reset_s = 1'b0; end
      HOLD:     begin cpu_reset_s = 1'b1; end
      default:  begin cpu_reset_s = 1'b1; end
    endcase
  end

  // output registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rom_en_r     <= 1'b0;
      sram_valid_r <= 1'b0;
      cfg_ready_r  <= 1'b0;
      cpu_reset_r  <= 1'b1;
      busy_r       <= 1'b1;
    end else if (cke_i) begin
      rom_en_r     <= rom_en_s;
      sram_valid_r <= sram_valid_s;
      cfg_ready_r  <= cfg_ready_s;
      cpu_reset_r  <= cpu_reset_s;
      busy_r       <= busy_s;
    end
  end

  // copy index, ROM data buffer and boot flag
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      idx_r  <= ROM_ADDR_W'(0);
      buf_r  <= DATA_W'(0);
      boot_r <= 1'b1;
    end else if (cke_i) begin
      if (reload_s) begin
        idx_r <= ROM_ADDR_W'(0);
      end else if (wr_hs_s && (idx_r != LAST_IDX)) begin
        idx_r <= idx_r + ROM_ADDR_W'(1);
      end
      if (state_r == COPY_CAP) begin
        buf_r <= rom_data_i;
      end
      if (cfg_hs_s) begin
        boot_r <= cfg_wdata_i[CFG_BOOT_BIT];
      end
    end
  end

`ifdef BOOT_CTRL_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_r;

  // running sum of accepted SRAM writes, restarted with each copy
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      checksum_r <= DATA_W'(0);
    end else if (cke_i) begin
      if (reload_s) begin
        checksum_r <= DATA_W'(0);
      end else if (wr_hs_s) begin
        checksum_r <= checksum_r + buf_r;
      end
    end
  end

  assign checksum_o = checksum_r;
`else
  assign checksum_o = DATA_W'(0);
`endif

  assign cfg_ready_o  = cfg_ready_r;
  assign rom_en_o     = rom_en_r;
  assign rom_addr_o   = idx_r;
  assign sram_valid_o = sram_valid_r;
  assign sram_addr_o  = BASE_ADDR + ADDR_W'(idx_r);
  assign sram_wdata_o = buf_r;
  assign sram_wstrb_o = {STRB_W{sram_valid_r}};
  assign boot_o       = boot_r;
  assign cpu_reset_o  = cpu_reset_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed self-checking bench for boot_ctrl: 4-word image at SRAM base 8,
// SRAM stall, software reset with and without reload, async reset mid-copy, clock enable.
module tb_boot_ctrl;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 12;
  localparam int ROM_ADDR_W = 10;
  localparam int ROM_WORDS  = 4;
  localparam int SRAM_BASE  = 8;
  localparam int RST_PULSE  = 100;
`ifdef BOOT_CTRL_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n, cke, cfg_valid, cfg_ready;
  logic [1:0]            cfg_wdata;
  logic                  rom_en;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0]     rom_q;
  logic                  sram_valid, sram_ready;
  logic [ADDR_W-1:0]     sram_addr;
  logic [DATA_W-1:0]     sram_wdata;
  logic [DATA_W/8-1:0]   sram_wstrb;
  logic                  boot, cpu_reset, busy;
  logic [DATA_W-1:0]     checksum;

  logic [DATA_W-1:0]     rom_mem [ROM_WORDS];
  logic [ADDR_W-1:0]     log_addr [64];
  logic [DATA_W-1:0]     log_data [64];
  int log_n = 0;
  int log_base = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  boot_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROM_ADDR_W(ROM_ADDR_W),
    .ROM_WORDS(ROM_WORDS), .SRAM_BASE(SRAM_BASE), .RST_PULSE(RST_PULSE)
  ) dut (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke),
    .cfg_valid_i(cfg_valid), .cfg_wdata_i(cfg_wdata), .cfg_ready_o(cfg_ready),
    .rom_en_o(rom_en), .rom_addr_o(rom_addr), .rom_data_i(rom_q),
    .sram_valid_o(sram_valid), .sram_ready_i(sram_ready), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_wstrb_o(sram_wstrb),
    .boot_o(boot), .cpu_reset_o(cpu_reset), .busy_o(busy), .checksum_o(checksum)
  );

  always #5 clk = ~clk;

  // synchronous ROM model and cycle counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_en) rom_q <= rom_mem[rom_addr[1:0]];
  end

  // record every SRAM write that will be accepted at the coming edge
  always @(negedge clk) begin
    if (rst_n && cke && sram_valid && sram_ready && log_n < 64) begin
      log_addr[log_n] <= sram_addr;
      log_data[log_n] <= sram_wdata;
      log_n <= log_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_boot"}, boot, 1);
    chk({tag, "_cpu_reset"}, cpu_reset, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_checksum"}, checksum, 0);
    chk({tag, "_cfg_ready"}, cfg_ready, 0);
    chk({tag, "_rom_en"}, rom_en, 0);
    chk({tag, "_sram_valid"}, sram_valid, 0);
    chk({tag, "_wstrb"}, sram_wstrb, 0);
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_count"}, log_n - log_base, ROM_WORDS);
    for (int i = 0; i < ROM_WORDS; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), log_addr[log_base + i], SRAM_BASE + i);
      chk($sformatf("%s_data%0d", tag, i), log_data[log_base + i], rom_mem[i]);
    end
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (cpu_reset && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_word2(input string tag);
    int n;
    n = 0;
    while (!(sram_valid && sram_addr == 12'd10) && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_found"}, sram_valid && (sram_addr == 12'd10), 1);
  endtask

  task automatic cfg_write(input logic [1:0] w);
    cfg_valid = 1'b1;
    cfg_wdata = w;
    tick();
    cfg_valid = 1'b0;
    cfg_wdata = 2'b00;
  endtask

  initial begin
    int n, reads, t0;
    logic stable;
    rst_n = 1'b0; cke = 1'b1; cfg_valid = 1'b0; cfg_wdata = 2'b00; sram_ready = 1'b1;
    for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = 32'h100 + i;

    // reset and initial load
    repeat (3) tick();
    chk_reset("rst");
    rst_n = 1'b1;
    chk("rom_en_pre", rom_en, 0);
    tick();
    chk("rom_en_first", rom_en, 1);
    chk("rom_addr_first", rom_addr, 0);
    wait_run(n);
    chk("load_len", n, 12);
    chk_log("load");
    chk("load_busy", busy, 0);
    chk("load_cfg_ready", cfg_ready, 1);
    chk("load_csum", checksum, CSUM_ON ? 32'h406 : 32'h0);

    // software reset without reload; cfg writes during HOLD are ignored
    cfg_write(2'b10);
    chk("sw_boot", boot, 0);
    chk("sw_cfg_ready", cfg_ready, 0);
    n = 0; reads = 0;
    while (cpu_reset === 1'b1 && n < 300) begin
      if (rom_en) reads++;
      n++;
      cfg_valid = (n >= 10 && n < 13);
      cfg_wdata = 2'b01;
      tick();
    end
    cfg_valid = 1'b0; cfg_wdata = 2'b00;
    chk("hold_len", n, RST_PULSE);
    chk("hold_reads", reads, 0);
    chk("hold_ignored_boot", boot, 0);
    chk("hold_back_run", cfg_ready, 1);

    // software reset with reload, SRAM stalls 5 cycles on word 2
    cfg_write(2'b11);
    chk("reload_boot", boot, 1);
    log_base = log_n;
    n = 1;
    while (!rom_en && n < 300) begin
      tick();
      n++;
    end
    chk("reload_delay", n, RST_PULSE + 1);
    t0 = cyc;
    wait_word2("stall");
    sram_ready = 1'b0;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      stable &= (sram_valid === 1'b1) && (sram_addr === 12'd10) &&
                (sram_wdata === 32'h102) && (sram_wstrb === 4'hf);
      tick();
    end
    sram_ready = 1'b1;
    chk("stall_stable", stable, 1);
    chk("stall_valid_end", sram_valid, 1);
    wait_run(n);
    chk("stall_len", cyc - t0, 17);
    chk_log("reload");
    chk("reload_cpu_reset", cpu_reset, 0);
    chk("reload_csum", checksum, CSUM_ON ? 32'h406 : 32'h0);

    // async reset during word 2, new image for checksum wrap
    rom_mem[0] = 32'hFFFF_FFFF; rom_mem[1] = 32'h2; rom_mem[2] = 32'h0; rom_mem[3] = 32'h0;
    cfg_write(2'b11);
    wait_word2("midrst");
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    repeat (2) tick();
    log_base = log_n;
    rst_n = 1'b1;
    chk("restart_rom_en_pre", rom_en, 0);
    tick();
    chk("restart_rom_en", rom_en, 1);
    chk("restart_rom_addr", rom_addr, 0);
    t0 = cyc;
    wait_run(n);
    chk("restart_len", cyc - t0, 12);
    chk_log("restart");
    chk("restart_csum", checksum, CSUM_ON ? 32'h1 : 32'h0);

    // clock enable low freezes everything, including cfg acceptance
    cke = 1'b0; cfg_valid = 1'b1; cfg_wdata = 2'b10;
    repeat (3) tick();
    chk("cke_boot", boot, 1);
    chk("cke_cpu_reset", cpu_reset, 0);
    chk("cke_cfg_ready", cfg_ready, 1);
    cke = 1'b1; cfg_valid = 1'b0; cfg_wdata = 2'b00;
    tick();
    cfg_write(2'b00);
    chk("flag_only_boot", boot, 0);
    chk("flag_only_cpu_reset", cpu_reset, 0);
    chk("flag_only_cfg_ready", cfg_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
